// File: rtl/cordic_phase_feeder_if.sv
// Bus between the angle feeder and its surroundings: frequency/clear
// controls in, CORDIC angle plus output-alignment flags out.
interface cordic_phase_feeder_if #(
    parameter int PHASE_W = 16
);
    logic [PHASE_W-1:0] freq_word;
    logic               load_freq;
    logic               phase_clr;
    logic [7:0]         angle;
    logic               frame_start;
    logic               cos_neg;
    logic               out_valid;

    modport master (
        output freq_word, load_freq, phase_clr,
        input  angle, frame_start, cos_neg, out_valid
    );

    modport slave (
        input  freq_word, load_freq, phase_clr,
        output angle, frame_start, cos_neg, out_valid
    );
endinterface

// File: rtl/cordic_phase_feeder.sv
// Frame-synchronous NCO feeding a CORDIC sine/cosine core. Each frame the
// phase is folded into +-pi/2, scaled to a Q2.6 radian angle and held for
// the whole frame; the cosine-negate flag is delayed to line up with the
// core's registered outputs.
module cordic_phase_feeder #(
    parameter int FRAME_LEN = 12,
    parameter int PHASE_W   = 16
) (
    input logic                  clk,
    input logic                  rst,
    cordic_phase_feeder_if.slave bus
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam int PW = PHASE_W + 11;  // product width: theta (PHASE_W+1) x 804 (11 bits)

    localparam logic [CW-1:0] FC_FOLD  = CW'(0);
    localparam logic [CW-1:0] FC_SCALE = CW'(1);
    localparam logic [CW-1:0] FC_LAST  = CW'(FRAME_LEN - 1);

    // Quarter and half turn in the sign-extended phase domain.
    localparam logic signed [PHASE_W:0] QUARTER = {2'b00, 1'b1, {(PHASE_W-2){1'b0}}};
    localparam logic signed [PHASE_W:0] HALF    = {1'b0, 1'b1, {(PHASE_W-1){1'b0}}};

    // 804 / 2^(PHASE_W+1) approximates 2*pi / 2^PHASE_W in Q2.6 units; ROUND is half an LSB.
    localparam logic signed [PW-1:0] SCALE = PW'(804);
    localparam logic signed [PW-1:0] ROUND = {{(PW-PHASE_W-1){1'b0}}, 1'b1, {PHASE_W{1'b0}}};

    logic [CW-1:0]             fc;
    logic [PHASE_W-1:0]        phase;
    logic [PHASE_W-1:0]        freq_reg;
    logic                      clr_pend;
    logic signed [PHASE_W:0]   theta_r;
    logic                      flag_r;
    logic [1:0]                fpipe;
    logic [1:0]                vpipe;
    logic [7:0]                angle_r;
    logic                      frame_start_r;
    logic                      cos_neg_r;
    logic                      out_valid_r;

    logic [PHASE_W-1:0]        freq_now;
    logic signed [PHASE_W:0]   ps_ext;
    logic signed [PHASE_W:0]   theta_nx;
    logic                      flag_nx;
    logic [7:0]                angle_nx;

    // A load in the advance cycle must already use the incoming word.
    assign freq_now = bus.load_freq ? bus.freq_word : freq_reg;
    assign ps_ext   = {phase[PHASE_W-1], phase};
    assign angle_nx = 8'((PW'(theta_r) * SCALE + ROUND) >>> (PHASE_W + 1));

    // Fold the signed phase into [-pi/2, +pi/2]; flag marks a reflected angle.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        theta_nx = ps_ext;
        flag_nx  = 1'b0;
        if (ps_ext > QUARTER) begin
            theta_nx = HALF - ps_ext;
            flag_nx  = 1'b1;
        end else if (ps_ext < -QUARTER) begin
            theta_nx = -HALF - ps_ext;
            flag_nx  = 1'b1;
        end
    end

    // Frame counter, frequency register and phase accumulator with deferred clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            fc       <= '0;
            freq_reg <= '0;
            phase    <= '0;
            clr_pend <= 1'b0;
        end else begin
            fc <= (fc == FC_LAST) ? '0 : fc + CW'(1);
            if (bus.load_freq)
                freq_reg <= bus.freq_word;
            if (fc == FC_LAST) begin
                phase    <= (clr_pend || bus.phase_clr) ? '0 : phase + freq_now;
                clr_pend <= 1'b0;
            end else if (bus.phase_clr) begin
                clr_pend <= 1'b1;
            end
        end
    end

    // Fold, scale and alignment pipeline, each stage firing once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            theta_r       <= '0;
            flag_r        <= 1'b0;
            fpipe         <= '0;
            vpipe         <= '0;
            angle_r       <= '0;
            frame_start_r <= 1'b0;
            cos_neg_r     <= 1'b0;
            out_valid_r   <= 1'b0;
        end else begin
            frame_start_r <= (fc == FC_SCALE);
            if (fc == FC_FOLD) begin
                theta_r     <= theta_nx;
                flag_r      <= flag_nx;
                cos_neg_r   <= fpipe[1];
                out_valid_r <= vpipe[1];
            end
            if (fc == FC_SCALE) begin
                angle_r <= angle_nx;
                fpipe   <= {fpipe[0], flag_r};
                vpipe   <= {vpipe[0], 1'b1};
            end
        end
    end

    assign bus.angle       = angle_r;
    assign bus.frame_start = frame_start_r;
    assign bus.cos_neg     = cos_neg_r;
    assign bus.out_valid   = out_valid_r;
endmodule

// File: tb/tb_cordic_phase_feeder.sv
// Directed bench for cordic_phase_feeder. Cycle index n counts from the
// first cycle after reset release; outputs are sampled 1 ns after each edge.
module tb_cordic_phase_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n = 0;
    int   compared = 0;
    int   mismatched = 0;

    cordic_phase_feeder_if #(.PHASE_W(16)) bus ();

    cordic_phase_feeder #(.FRAME_LEN(12), .PHASE_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic go_to(input int target);
        while (n < target) tick();
    endtask

    task automatic release_reset();
        rst = 1'b1;
        bus.load_freq = 1'b0;
        bus.phase_clr = 1'b0;
        bus.freq_word = '0;
        tick();
        tick();
        rst = 1'b0;
        n = 0;
    endtask

    task automatic load(input logic [15:0] w);
        bus.freq_word = w;
        bus.load_freq = 1'b1;
        tick();
        bus.load_freq = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        compared++;
        if (bus.angle !== 8'h00) begin
            mismatched++; $display("FAIL reset_angle got=%h want=00", bus.angle);
        end
        compared++;
        if (bus.frame_start !== 1'b0) begin
            mismatched++; $display("FAIL reset_frame_start got=%b want=0", bus.frame_start);
        end
        compared++;
        if (bus.cos_neg !== 1'b0) begin
            mismatched++; $display("FAIL reset_cos_neg got=%b want=0", bus.cos_neg);
        end
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        release_reset();
        for (int c = 0; c <= 40; c++) begin
            go_to(c);
            compared++;
            if (bus.frame_start !== (c % 12 == 2)) begin
                mismatched++; $display("FAIL zero_frame_start n=%0d got=%b want=%b", c, bus.frame_start, (c % 12 == 2));
            end
            compared++;
            if (bus.angle !== 8'h00) begin
                mismatched++; $display("FAIL zero_angle n=%0d got=%h want=00", c, bus.angle);
            end
            compared++;
            if (bus.out_valid !== (c >= 25)) begin
                mismatched++; $display("FAIL zero_out_valid n=%0d got=%b want=%b", c, bus.out_valid, (c >= 25));
            end
            compared++;
            if (bus.cos_neg !== 1'b0) begin
                mismatched++; $display("FAIL zero_cos_neg n=%0d got=%b want=0", c, bus.cos_neg);
            end
        end
    endtask

    task automatic test_quarter();
        logic [7:0] aq [4] = '{8'h00, 8'h65, 8'h00, 8'h9C};
        logic       cq [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        release_reset();
        load(16'd16384);
        for (int c = 2; c <= 61; c++) begin
            go_to(c);
            if (c <= 49 && (c % 12 == 2 || c % 12 == 1)) begin
                compared++;
                if (bus.angle !== aq[(c-2)/12]) begin
                    mismatched++; $display("FAIL quarter_angle n=%0d got=%h want=%h", c, bus.angle, aq[(c-2)/12]);
                end
            end
            if (c >= 25 && c % 12 == 1) begin
                compared++;
                if (bus.cos_neg !== cq[(c-25)/12]) begin
                    mismatched++; $display("FAIL quarter_cos_neg n=%0d got=%b want=%b", c, bus.cos_neg, cq[(c-25)/12]);
                end
            end
            if (c == 24 || c == 25) begin
                compared++;
                if (bus.out_valid !== (c == 25)) begin
                    mismatched++; $display("FAIL quarter_out_valid n=%0d got=%b want=%b", c, bus.out_valid, (c == 25));
                end
            end
        end
    endtask

    task automatic test_eighth();
        logic [7:0] ae [4] = '{8'h00, 8'h32, 8'h65, 8'h32};
        logic       ce [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        release_reset();
        load(16'd8192);
        for (int c = 2; c <= 61; c++) begin
            go_to(c);
            if (c <= 49 && (c % 12 == 2 || c % 12 == 1)) begin
                compared++;
                if (bus.angle !== ae[(c-2)/12]) begin
                    mismatched++; $display("FAIL eighth_angle n=%0d got=%h want=%h", c, bus.angle, ae[(c-2)/12]);
                end
            end
            if (c >= 25 && c % 12 == 1) begin
                compared++;
                if (bus.cos_neg !== ce[(c-25)/12]) begin
                    mismatched++; $display("FAIL eighth_cos_neg n=%0d got=%b want=%b", c, bus.cos_neg, ce[(c-25)/12]);
                end
            end
        end
    endtask

    task automatic test_clear_load();
        release_reset();
        load(16'd8192);
        go_to(14);
        compared++;
        if (bus.angle !== 8'h32) begin
            mismatched++; $display("FAIL clr_pre_angle got=%h want=32", bus.angle);
        end
        // Clear and new frequency together in cycle 11 of frame 1.
        go_to(23);
        bus.phase_clr = 1'b1;
        bus.freq_word = 16'd4096;
        bus.load_freq = 1'b1;
        tick();
        bus.phase_clr = 1'b0;
        bus.load_freq = 1'b0;
        go_to(26);
        compared++;
        if (bus.angle !== 8'h00) begin
            mismatched++; $display("FAIL clr_same_cycle_angle got=%h want=00", bus.angle);
        end
        go_to(38);
        compared++;
        if (bus.angle !== 8'h19) begin
            mismatched++; $display("FAIL clr_next_angle got=%h want=19", bus.angle);
        end
        // Mid-frame clear stays pending until the next advance.
        go_to(40);
        bus.phase_clr = 1'b1;
        tick();
        bus.phase_clr = 1'b0;
        go_to(50);
        compared++;
        if (bus.angle !== 8'h00) begin
            mismatched++; $display("FAIL clr_pending_angle got=%h want=00", bus.angle);
        end
        go_to(62);
        compared++;
        if (bus.angle !== 8'h19) begin
            mismatched++; $display("FAIL clr_pending_next_angle got=%h want=19", bus.angle);
        end
        // Plain load in cycle 11: advance uses the new word (4096 + 12288).
        go_to(71);
        load(16'd12288);
        go_to(74);
        compared++;
        if (bus.angle !== 8'h65) begin
            mismatched++; $display("FAIL load_last_cycle_angle got=%h want=65", bus.angle);
        end
    endtask

    task automatic test_mid_reset();
        release_reset();
        load(16'd8192);
        go_to(66);
        compared++;
        if (bus.angle !== 8'hCE) begin
            mismatched++; $display("FAIL mid_pre_angle got=%h want=ce", bus.angle);
        end
        compared++;
        if (bus.cos_neg !== 1'b1 || bus.out_valid !== 1'b1) begin
            mismatched++; $display("FAIL mid_pre_flags got=%b%b want=11", bus.cos_neg, bus.out_valid);
        end
        rst = 1'b1;
        tick();
        compared++;
        if (bus.angle !== 8'h00) begin
            mismatched++; $display("FAIL mid_rst_angle got=%h want=00", bus.angle);
        end
        compared++;
        if (bus.cos_neg !== 1'b0) begin
            mismatched++; $display("FAIL mid_rst_cos_neg got=%b want=0", bus.cos_neg);
        end
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++; $display("FAIL mid_rst_out_valid got=%b want=0", bus.out_valid);
        end
        compared++;
        if (bus.frame_start !== 1'b0) begin
            mismatched++; $display("FAIL mid_rst_frame_start got=%b want=0", bus.frame_start);
        end
        rst = 1'b0;
        n = 0;
        for (int c = 0; c <= 37; c++) begin
            go_to(c);
            compared++;
            if (bus.out_valid !== (c >= 25)) begin
                mismatched++; $display("FAIL mid_refill_out_valid n=%0d got=%b want=%b", c, bus.out_valid, (c >= 25));
            end
            compared++;
            if (bus.cos_neg !== 1'b0) begin
                mismatched++; $display("FAIL mid_refill_cos_neg n=%0d got=%b want=0", c, bus.cos_neg);
            end
            compared++;
            if (bus.frame_start !== (c % 12 == 2)) begin
                mismatched++; $display("FAIL mid_refill_frame_start n=%0d got=%b want=%b", c, bus.frame_start, (c % 12 == 2));
            end
        end
        compared++;
        if (bus.angle !== 8'h00) begin
            mismatched++; $display("FAIL mid_refill_angle got=%h want=00", bus.angle);
        end
    endtask

    task automatic test_neg_step();
        release_reset();
        load(16'hFFFF);
        for (int c = 2; c <= 61; c++) begin
            go_to(c);
            compared++;
            if (bus.angle !== 8'h00) begin
                mismatched++; $display("FAIL neg_angle n=%0d got=%h want=00", c, bus.angle);
            end
            compared++;
            if (bus.cos_neg !== 1'b0) begin
                mismatched++; $display("FAIL neg_cos_neg n=%0d got=%b want=0", c, bus.cos_neg);
            end
            compared++;
            if (bus.out_valid !== (c >= 25)) begin
                mismatched++; $display("FAIL neg_out_valid n=%0d got=%b want=%b", c, bus.out_valid, (c >= 25));
            end
        end
    endtask

    initial begin
        bus.freq_word = '0;
        bus.load_freq = 1'b0;
        bus.phase_clr = 1'b0;
        test_reset();
        test_quarter();
        test_eighth();
        test_clear_load();
        test_mid_reset();
        test_neg_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
